dog_stream_arbiter: RTL and testbench
=====================================

// Module: dog_stream_arbiter
// PURPOSE
//  Shares one output port among the four difference-of-Gaussian streams (d0..d3) produced by an octave.
//  Tags each pixel with its scale index and its (x,y) frame coordinate.
//  Sits between the octave's difference outputs and the single downstream consumer (keypoint/extrema stage or frame writer).
//  The DoG sources cannot stall, so each stream is buffered in a small FIFO and drained round-robin under a ready/valid handshake.
// PARAMETERS
//  WIDTH       420  pixels per row of the octave being served (210 for the second octave)
//  HEIGHT      320  rows per frame
//  FIFO_DEPTH  16   entries per stream FIFO; must be a power of two, >= 4
//  XW          9    x-coordinate width; must satisfy 2**XW >= WIDTH
//  YW          9    y-coordinate width; must satisfy 2**YW >= HEIGHT
// PORTS
//  clock          in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  frame_start    in   1   one-cycle pulse; zeroes all four stream coordinate counters
//  d_data         in   32  {d3,d2,d1,d0}, 8 bits each
//  d_valid        in   4   per-stream valid; no backpressure to the source
//  out_ready      in   1   consumer accepts out_* this cycle
//  out_valid      out  1   out_* holds a pixel
//  out_data       out  8   DoG pixel
//  out_scale      out  2   source stream index (0..3)
//  out_x          out  XW  column of the pixel
//  out_y          out  YW  row of the pixel
//  overflow       out  4   sticky per-stream flag: a pixel was dropped because the FIFO was full
//  clear_overflow in   1   clears all overflow bits
// BEHAVIOUR
//  Reset: out_valid=0, out_data/out_scale/out_x/out_y=0, overflow=0, all FIFOs empty, all counters 0, rr pointer=3.
//  Coordinates: per-stream counters x_i, y_i advance on every d_valid[i], including dropped pixels, so tags stay correct.
//    x_i wraps from WIDTH-1 to 0 and increments y_i; y_i wraps from HEIGHT-1 to 0.
//    The FIFO word is {y_i, x_i, data}, written with the pre-increment counter values.
//  frame_start: zeroes all x_i and y_i. If d_valid[i] arrives in the same cycle, that pixel is tagged (0,0) and the counters go to (1,0).
//  Drop: d_valid[i] while FIFO i is full (pre-pop occupancy) -> word discarded, overflow[i] set.
//    A simultaneous pop does not rescue the write.
//  clear_overflow has priority over a new overflow event in the same cycle; the bit reads 0 afterwards.
//  Output register load condition: load = !out_valid | out_ready.
//    On load, if any FIFO is non-empty, grant stream g = first non-empty index after rr in cyclic order (rr+1, rr+2, ...).
//    Pop that FIFO, register the word into out_*, set out_valid=1, set rr=g.
//    On load with all FIFOs empty: out_valid=0; out_data etc. hold their last value.
//  While out_valid & !out_ready, all out_* are held stable and no FIFO is popped.
//  Latency: d_valid[i] in cycle N -> out_valid earliest in cycle N+2 (FIFO write N, pop/register N+1).
//  Throughput: 1 pixel/cycle total. Fairness: each non-empty stream is served at least once every 4 grants.
//  Each FIFO is first-word-fall-through. Within one stream, ordering is preserved.
//  Reset mid-frame: everything returns to reset values immediately; no partial word is emitted.
// STRUCTURE
//  Shared header sift_defs.vh: NUM_DOG_STREAMS=4, DOG_PIX_W=8, SCALE_W=2, octave WIDTH/HEIGHT constants.
//  Sub-module dog_stream_fifo (sync FWFT FIFO with full/empty), instantiated 4x in a generate loop.
//  Round-robin grant and the coordinate counters stay inline in this module.
// TESTING
//  1. Single pixel d_valid=4'b0100, d_data[23:16]=8'h5A, out_ready=1 -> two cycles later: out_valid=1, data=5A, scale=2, x=0, y=0.
//  2. All four valid for 4 cycles with out_ready=1 -> 16 outputs; scale order 0,1,2,3 repeating; per-stream x=0,1,2,3.
//  3. Stream 1 alone for WIDTH+1 pixels -> last pixel tagged x=0, y=1. Then frame_start with a valid -> pixel tagged (0,0).
//  4. out_ready=0 while stream 0 streams 20 pixels (FIFO_DEPTH=16) -> overflow=4'b0001.
//     After release: exactly 17 outputs (16 buffered + 1 held), x=0..16; clear_overflow -> overflow=0.
//  5. out_ready toggles 1,0,1,0 with all streams busy -> out_* stable whenever out_ready=0; no lost or duplicated pixel (scoreboard).
//  6. Assert reset asynchronously mid-burst -> out_valid=0 and overflow=0 within the same cycle.
//     After release, the first output is the next new pixel, tagged from (0,0).

Source files
------------

// File: rtl/dog_stream_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dog_stream_arbiter_pkg
//   Shared constants and types for the difference-of-Gaussian stream
//   arbiter: stream count, pixel/scale widths and the octave geometries.
//   No ports (package).
// ---------------------------------------------------------------------------
package dog_stream_arbiter_pkg;

  localparam int NUM_DOG_STREAMS = 4;
  localparam int DOG_PIX_W       = 8;
  localparam int SCALE_W         = 2;

  // Octave geometries served by the arbiter.
  localparam int OCT0_WIDTH = 420;
  localparam int OCT1_WIDTH = 210;
  localparam int OCT_HEIGHT = 320;

  typedef logic [SCALE_W-1:0] scale_t;

  // Stream index k steps after base in cyclic order (wraps modulo 4).
  function automatic scale_t scale_step(input scale_t base, input int k);
    return scale_t'(base + scale_t'(k));
  endfunction

endpackage

// File: rtl/dog_stream_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// dog_stream_arbiter_fifo
//   Synchronous first-word-fall-through FIFO used to buffer one DoG stream.
//   rd_data always shows the oldest entry while empty=0; a write that finds
//   the FIFO full is ignored (occupancy is taken before any same-cycle pop).
// Ports
//   clock    in   system clock
//   reset    in   asynchronous active-high reset (pointers and count only)
//   wr_en    in   push wr_data (ignored when full)
//   wr_data  in   DW-bit word to store
//   rd_en    in   pop the head entry (ignored when empty)
//   rd_data  out  head entry (valid while empty=0)
//   full     out  DEPTH entries stored
//   empty    out  no entries stored
// ---------------------------------------------------------------------------
module dog_stream_arbiter_fifo
  import dog_stream_arbiter_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 26
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // Small, shallow store: read asynchronously so the head word is visible
  // the cycle after it is written (fall-through behaviour).
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dog_stream_arbiter.sv
// ---------------------------------------------------------------------------
// dog_stream_arbiter
//   Merges the four difference-of-Gaussian streams of one octave onto a
//   single ready/valid output. Each pixel is tagged with its stream (scale)
//   index and its (x,y) frame coordinate. The sources cannot stall, so every
//   stream is buffered in a FIFO; FIFOs are drained round-robin.
// Ports
//   clock           in   system clock
//   reset           in   asynchronous active-high reset
//   frame_start     in   pulse: zero all stream coordinate counters
//   d_data[31:0]    in   {d3,d2,d1,d0}, 8 bits each
//   d_valid[3:0]    in   per-stream valid (no backpressure)
//   out_ready       in   consumer accepts out_* this cycle
//   out_valid       out  out_* holds a pixel
//   out_data[7:0]   out  DoG pixel
//   out_scale[1:0]  out  source stream index
//   out_x[XW-1:0]   out  pixel column
//   out_y[YW-1:0]   out  pixel row
//   overflow[3:0]   out  sticky per-stream drop flag
//   clear_overflow  in   clear all overflow flags (wins over a new drop)
// ---------------------------------------------------------------------------
module dog_stream_arbiter
  import dog_stream_arbiter_pkg::*;
#(
  parameter int WIDTH      = OCT0_WIDTH,
  parameter int HEIGHT     = OCT_HEIGHT,
  parameter int FIFO_DEPTH = 16,
  parameter int XW         = 9,
  parameter int YW         = 9
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 frame_start,
  input  logic [NUM_DOG_STREAMS*DOG_PIX_W-1:0] d_data,
  input  logic [NUM_DOG_STREAMS-1:0]           d_valid,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [DOG_PIX_W-1:0]                 out_data,
  output logic [SCALE_W-1:0]                   out_scale,
  output logic [XW-1:0]                        out_x,
  output logic [YW-1:0]                        out_y,
  output logic [NUM_DOG_STREAMS-1:0]           overflow,
  input  logic                                 clear_overflow
);

  // FIFO word layout: {y, x, data}
  localparam int WW = YW + XW + DOG_PIX_W;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [WW-1:0]              fifo_word [NUM_DOG_STREAMS];
  logic [NUM_DOG_STREAMS-1:0] fifo_full;
  logic [NUM_DOG_STREAMS-1:0] fifo_empty;
  logic [NUM_DOG_STREAMS-1:0] pop;
  scale_t                     rr_reg;
  scale_t                     grant;
  logic                       grant_found;
  logic                       load;

  // The output register may take a new word when it is empty or being consumed.
  assign load = ~out_valid | out_ready;

  for (genvar gi = 0; gi < NUM_DOG_STREAMS; gi++) begin : g_stream
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [XW-1:0] tag_x;
    logic [YW-1:0] tag_y;

    // A frame_start in the same cycle as a pixel tags that pixel (0,0).
    assign tag_x = frame_start ? '0 : x_reg;
    assign tag_y = frame_start ? '0 : y_reg;

    // Counters advance on every valid, even dropped ones, so tags stay aligned.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        x_reg <= '0;
        y_reg <= '0;
      end else if (d_valid[gi]) begin
        if (tag_x == X_LAST) begin
          x_reg <= '0;
          y_reg <= (tag_y == Y_LAST) ? '0 : tag_y + 1'b1;
        end else begin
          x_reg <= tag_x + 1'b1;
          y_reg <= tag_y;
        end
      end else if (frame_start) begin
        x_reg <= '0;
        y_reg <= '0;
      end
    end

    dog_stream_arbiter_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (WW)
    ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (d_valid[gi]),
      .wr_data ({tag_y, tag_x, d_data[gi*DOG_PIX_W +: DOG_PIX_W]}),
      .rd_en   (pop[gi]),
      .rd_data (fifo_word[gi]),
      .full    (fifo_full[gi]),
      .empty   (fifo_empty[gi])
    );

    assign pop[gi] = load & grant_found & (grant == scale_t'(gi));
  end

  // Round-robin: first non-empty stream strictly after the last grant.
  always_comb begin
    grant       = rr_reg;
    grant_found = 1'b0;
    for (int k = 1; k <= NUM_DOG_STREAMS; k++) begin
      if (!grant_found && !fifo_empty[scale_step(rr_reg, k)]) begin
        grant       = scale_step(rr_reg, k);
        grant_found = 1'b1;
      end
    end
  end

  // Sticky drop flags; the drop test uses the pre-pop full flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= '0;
    end else if (clear_overflow) begin
      overflow <= '0;
    end else begin
      overflow <= overflow | (d_valid & fifo_full);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_scale <= '0;
      out_x     <= '0;
      out_y     <= '0;
      rr_reg    <= scale_t'(NUM_DOG_STREAMS - 1);
    end else if (load) begin
      if (grant_found) begin
        out_valid                 <= 1'b1;
        {out_y, out_x, out_data}  <= fifo_word[grant];
        out_scale                 <= grant;
        rr_reg                    <= grant;
      end else begin
        // Nothing to send: drop valid, leave the payload as it was.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dog_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dog_stream_arbiter
//   Randomised and directed stimulus for dog_stream_arbiter. A queue-based
//   reference model predicts each granted word into a scoreboard; a separate
//   monitor pops and compares whenever the DUT hands a pixel over.
// ---------------------------------------------------------------------------
module tb_dog_stream_arbiter;

  localparam int W     = 10;
  localparam int H     = 4;
  localparam int DEPTH = 16;
  localparam int XW    = 9;
  localparam int YW    = 9;

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [31:0]   d_data;
  logic [3:0]    d_valid;
  logic          out_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [1:0]    out_scale;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [3:0]    overflow;
  logic          clear_overflow;

  always #5 clock = ~clock;

  dog_stream_arbiter #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .FIFO_DEPTH (DEPTH),
    .XW         (XW),
    .YW         (YW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_start    (frame_start),
    .d_data         (d_data),
    .d_valid        (d_valid),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_scale      (out_scale),
    .out_x          (out_x),
    .out_y          (out_y),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] scale;
    int         x;
    int         y;
  } pix_t;

  int vectors    = 0;
  int miscompares = 0;
  int xfers      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // q[i] holds words waiting in stream i's buffer; pix_cnt[i] counts pixels
  // since the last frame_start (coordinate = position in raster order).
  pix_t       q [4][$];
  pix_t       sb [$];
  int         pix_cnt [4];
  int         m_rr;
  bit         m_valid;
  logic [3:0] m_ovf;
  int         sz [4];
  bit         found;
  int         g;
  logic [3:0] new_drop;
  pix_t       p;

  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        pix_cnt[i] = 0;
      end
      sb.delete();
      m_rr    = 3;
      m_valid = 1'b0;
      m_ovf   = 4'b0;
    end else begin
      check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("overflow", {28'b0, overflow}, {28'b0, m_ovf});
      for (int i = 0; i < 4; i++) sz[i] = q[i].size();
      // grant decision for the coming edge
      if (!m_valid || out_ready) begin
        found = 1'b0;
        g     = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && q[(m_rr + k) % 4].size() > 0) begin
            found = 1'b1;
            g     = (m_rr + k) % 4;
          end
        end
        if (found) begin
          sb.push_back(q[g].pop_front());
          m_rr    = g;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      // arrivals
      if (frame_start) for (int i = 0; i < 4; i++) pix_cnt[i] = 0;
      new_drop = 4'b0;
      for (int i = 0; i < 4; i++) begin
        if (d_valid[i]) begin
          if (sz[i] >= DEPTH) begin
            new_drop[i] = 1'b1;
          end else begin
            p.data  = d_data[8*i +: 8];
            p.scale = 2'(i);
            p.x     = pix_cnt[i] % W;
            p.y     = (pix_cnt[i] / W) % H;
            q[i].push_back(p);
          end
          pix_cnt[i] = (pix_cnt[i] + 1) % (W * H);
        end
      end
      m_ovf = clear_overflow ? 4'b0 : (m_ovf | new_drop);
    end
  end

  // ---------------- monitor ----------------
  bit         hold = 1'b0;
  logic [7:0] h_data;
  logic [1:0] h_scale;
  logic [XW-1:0] h_x;
  logic [YW-1:0] h_y;
  pix_t       e;

  always @(negedge clock) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_data", {24'b0, out_data}, {24'b0, h_data});
        check("hold_scale", {30'b0, out_scale}, {30'b0, h_scale});
        check("hold_x", 32'(out_x), 32'(h_x));
        check("hold_y", 32'(out_y), 32'(h_y));
      end
      if (out_valid && out_ready) begin
        xfers++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: got pixel %0h scale %0d, required nothing pending",
                   out_data, out_scale);
        end else begin
          e = sb.pop_front();
          check("sb_data", {24'b0, out_data}, {24'b0, e.data});
          check("sb_scale", {30'b0, out_scale}, {30'b0, e.scale});
          check("sb_x", 32'(out_x), 32'(e.x));
          check("sb_y", 32'(out_y), 32'(e.y));
        end
      end
      hold    = out_valid && !out_ready;
      h_data  = out_data;
      h_scale = out_scale;
      h_x     = out_x;
      h_y     = out_y;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    d_valid     = 4'b0;
    frame_start = 1'b0;
    repeat (n) cyc();
  endtask

  int xs;

  initial begin
    reset          = 1'b1;
    frame_start    = 1'b0;
    d_valid        = 4'b0;
    d_data         = 32'b0;
    out_ready      = 1'b1;
    clear_overflow = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;

    // reset state
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data", {24'b0, out_data}, 32'd0);
    check("rst_scale", {30'b0, out_scale}, 32'd0);
    check("rst_x", 32'(out_x), 32'd0);
    check("rst_y", 32'(out_y), 32'd0);
    check("rst_ovf", {28'b0, overflow}, 32'd0);

    // 1: single pixel on stream 2, two-cycle latency
    cyc();
    d_valid = 4'b0100;
    d_data  = 32'h005A_0000;
    cyc();
    d_valid = 4'b0;
    check("t1_not_yet", {31'b0, out_valid}, 32'd0);
    cyc();
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_data", {24'b0, out_data}, 32'h5A);
    check("t1_scale", {30'b0, out_scale}, 32'd2);
    check("t1_x", 32'(out_x), 32'd0);
    check("t1_y", 32'(out_y), 32'd0);
    idle(4);

    // 2: all four streams for 4 cycles
    for (int c = 0; c < 4; c++) begin
      d_valid = 4'b1111;
      d_data  = $urandom;
      cyc();
    end
    idle(24);

    // 3: stream 1 alone for W+1 pixels, then frame_start with a pixel
    for (int c = 0; c <= W; c++) begin
      frame_start = (c == 0);
      d_valid     = 4'b0010;
      d_data      = $urandom;
      cyc();
    end
    frame_start = 1'b1;
    d_valid     = 4'b0010;
    d_data      = $urandom;
    cyc();
    idle(8);

    // 4: overflow of stream 0 while the consumer stalls
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      frame_start = (c == 0);
      d_valid     = 4'b0001;
      d_data      = $urandom;
      cyc();
    end
    idle(1);
    check("t4_ovf", {28'b0, overflow}, 32'b0001);
    xs        = xfers;
    out_ready = 1'b1;
    idle(30);
    check("t4_count", 32'(xfers - xs), 32'd17);
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    check("t4_clear", {28'b0, overflow}, 32'd0);

    // clear wins over a drop in the same cycle
    out_ready = 1'b0;
    for (int c = 0; c < 19; c++) begin
      d_valid        = 4'b0100;
      d_data         = $urandom;
      clear_overflow = (c == 18);
      cyc();
    end
    clear_overflow = 1'b0;
    idle(1);
    check("t4_clr_prio", {28'b0, overflow}, 32'd0);
    out_ready = 1'b1;
    idle(30);

    // 5: toggling ready, then random ready, all streams busy
    for (int c = 0; c < 400; c++) begin
      out_ready      = (c < 200) ? ((c % 2) == 0) : ($urandom_range(0, 3) != 0);
      d_valid        = 4'($urandom);
      d_data         = $urandom;
      frame_start    = ($urandom_range(0, 49) == 0);
      clear_overflow = ($urandom_range(0, 39) == 0);
      cyc();
    end
    clear_overflow = 1'b0;
    out_ready      = 1'b1;
    idle(80);

    // 6: asynchronous reset mid-burst
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      d_valid = 4'b1111;
      d_data  = $urandom;
      cyc();
    end
    @(posedge clock);
    #3;
    reset   = 1'b1;
    d_valid = 4'b0;
    #1;
    check("t6_valid", {31'b0, out_valid}, 32'd0);
    check("t6_ovf", {28'b0, overflow}, 32'd0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    out_ready = 1'b1;
    cyc();
    d_valid = 4'b1000;
    d_data  = 32'hC300_0000;
    cyc();
    d_valid = 4'b0;
    check("t6_not_yet", {31'b0, out_valid}, 32'd0);
    cyc();
    check("t6_first", {31'b0, out_valid}, 32'd1);
    check("t6_data", {24'b0, out_data}, 32'hC3);
    check("t6_scale", {30'b0, out_scale}, 32'd3);
    check("t6_x", 32'(out_x), 32'd0);
    check("t6_y", 32'(out_y), 32'd0);
    idle(10);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
